// File: rtl/gcd_multi_if.sv
// Request/result handshake bundle for gcd_multi.
// Stats ports exist only when GCD_MULTI_STATS_EN is defined.
interface gcd_multi_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bits;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef GCD_MULTI_STATS_EN
  logic [31:0]      stat_done_count;
  logic [15:0]      stat_max_lat;
`endif

  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_bits, out_tag, busy
`ifdef GCD_MULTI_STATS_EN
    , input stat_done_count, stat_max_lat
`endif
  );

  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_bits, out_tag, busy
`ifdef GCD_MULTI_STATS_EN
    , output stat_done_count, stat_max_lat
`endif
  );
endinterface

// File: rtl/gcd_multi.sv
// NUM_LANES parallel subtractive GCD lanes with tagged, round-robin, backpressured results.
// Optional statistics counters are built when GCD_MULTI_STATS_EN is defined.
module gcd_multi #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAG_W     = 4
) (
  input logic         clock,
  input logic         reset_n,
  gcd_multi_if.slave  bus
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } lane_state_e;

  lane_state_e      state_q [NUM_LANES];
  lane_state_e      state_d [NUM_LANES];
  logic [WIDTH-1:0] x_q     [NUM_LANES];
  logic [WIDTH-1:0] x_d     [NUM_LANES];
  logic [WIDTH-1:0] y_q     [NUM_LANES];
  logic [WIDTH-1:0] y_d     [NUM_LANES];
  logic [TAG_W-1:0] tag_q   [NUM_LANES];
  logic [TAG_W-1:0] tag_d   [NUM_LANES];

  logic [LANE_W-1:0] ptr_q, ptr_d;
  logic [LANE_W-1:0] grant_q, grant_d;
  logic              lock_q, lock_d;

  logic [LANE_W-1:0] free_idx;
  logic [LANE_W-1:0] rr_idx;
  logic [LANE_W-1:0] sel;
  logic              any_idle;
  logic              any_busy;
  logic              rr_found;
  logic              out_valid_c;
  logic              accept;
  logic              handshake;

  // Lowest-index idle lane receives the next request.
  always_comb begin
    any_idle = 1'b0;
    any_busy = 1'b0;
    free_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (state_q[LANE_W'(i)] == IDLE) begin
        any_idle = 1'b1;
        free_idx = LANE_W'(i);
      end else begin
        any_busy = 1'b1;
      end
    end
  end

  // First DONE lane at or after the round-robin pointer.
  always_comb begin
    int unsigned k;
    k        = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      k = (32'(ptr_q) + i) % NUM_LANES;
      if (!rr_found && state_q[LANE_W'(k)] == DONE) begin
        rr_found = 1'b1;
        rr_idx   = LANE_W'(k);
      end
    end
  end

  // A stalled grant stays put so the presented result cannot change under the consumer.
  assign sel         = lock_q ? grant_q : rr_idx;
  assign out_valid_c = lock_q | rr_found;
  assign handshake   = out_valid_c & bus.out_ready;
  assign accept      = bus.in_valid & any_idle;

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      tag_d[i]   = tag_q[i];
      case (state_q[i])
        IDLE: begin
          if (accept && free_idx == LANE_W'(i)) begin
            state_d[i] = COMPUTE;
            x_d[i]     = bus.in_x;
            y_d[i]     = bus.in_y;
            tag_d[i]   = bus.in_tag;
          end
        end
        COMPUTE: begin
          // Result is parked in x once either operand hits zero.
          if (x_q[i] == '0 || y_q[i] == '0) begin
            x_d[i]     = x_q[i] | y_q[i];
            state_d[i] = DONE;
          end else if (x_q[i] > y_q[i]) begin
            x_d[i] = x_q[i] - y_q[i];
          end else begin
            y_d[i] = y_q[i] - x_q[i];
          end
        end
        DONE: begin
          if (handshake && sel == LANE_W'(i)) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
    if (handshake) begin
      ptr_d  = (sel == LANE_W'(NUM_LANES - 1)) ? '0 : sel + LANE_W'(1);
      lock_d = 1'b0;
    end else if (out_valid_c) begin
      lock_d  = 1'b1;
      grant_d = sel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  assign bus.in_ready  = any_idle;
  assign bus.busy      = any_busy;
  assign bus.out_valid = out_valid_c;
  assign bus.out_bits  = out_valid_c ? x_q[sel]   : '0;
  assign bus.out_tag   = out_valid_c ? tag_q[sel] : '0;

`ifdef GCD_MULTI_STATS_EN
  logic [15:0] lat_q [NUM_LANES];
  logic [31:0] done_cnt_q;
  logic [15:0] max_lat_q;
  logic [15:0] hs_lat_c;

  // Latency includes the handshake edge itself.
  assign hs_lat_c = (lat_q[sel] == 16'hFFFF) ? 16'hFFFF : lat_q[sel] + 16'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt_q <= '0;
      max_lat_q  <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) lat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (accept && state_q[i] == IDLE && free_idx == LANE_W'(i)) begin
          lat_q[i] <= '0;
        end else if (state_q[i] != IDLE && lat_q[i] != 16'hFFFF) begin
          lat_q[i] <= lat_q[i] + 16'd1;
        end
      end
      if (handshake) begin
        done_cnt_q <= done_cnt_q + 32'd1;
        if (hs_lat_c > max_lat_q) max_lat_q <= hs_lat_c;
      end
    end
  end

  assign bus.stat_done_count = done_cnt_q;
  assign bus.stat_max_lat    = max_lat_q;
`endif

endmodule

// File: tb/tb_gcd_multi.sv
// Randomized and directed bench for gcd_multi with an arithmetic GCD scoreboard.
module tb_gcd_multi;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NL    = 4;
  localparam int unsigned TAG_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  gcd_multi_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  gcd_multi #(.WIDTH(WIDTH), .NUM_LANES(NL), .TAG_W(TAG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
  } pend_t;

  pend_t q[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_bits  = '0;
  logic [TAG_W-1:0] prev_tag   = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive step count equals the sum of the Euclidean quotients.
  function automatic int unsigned steps_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned s = 0;
    while (a != 0 && b != 0) begin
      if (a >= b) begin
        s += int'(a / b);
        a = a % b;
      end else begin
        s += int'(b / a);
        b = b % a;
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Scoreboard and per-cycle invariants, sampled mid low phase.
  always begin
    int idx;
    @(negedge clock);
    #1;
    if (!reset_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < NL));
      check("busy", 64'(bus.busy), 64'(q.size() != 0));
      if (q.size() == 0) check("empty_valid", 64'(bus.out_valid), 64'(0));
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_bits", 64'(bus.out_bits), 64'(prev_bits));
        check("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].tag == bus.out_tag) idx = i;
        check("tag_known", 64'(idx >= 0), 64'(1));
        if (idx >= 0) begin
          check("result", 64'(bus.out_bits), 64'(q[idx].res));
          q.delete(idx);
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back('{bus.in_tag, gcd_ref(bus.in_x, bus.in_y)});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bits  = bus.out_bits;
      prev_tag   = bus.out_tag;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
    int n = 0;
    bus.in_x = x; bus.in_y = y; bus.in_tag = t; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 5000) begin tick(); n++; end
    if (n >= 5000) check("send_timeout", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 5000) begin tick(); n++; end
    if (n >= 5000) check("valid_timeout", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic run_one(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
    int n = 0;
    bus.out_ready = 1'b1;
    send(x, y, t);
    while (!bus.out_valid && n < 5000) begin tick(); n++; end
    check("latency", 64'(n), 64'(steps_ref(x, y) + 1));
    check("one_bits", 64'(bus.out_bits), 64'(gcd_ref(x, y)));
    check("one_tag", 64'(bus.out_tag), 64'(t));
    tick();
    check("busy_after", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int acc_n, hs_n, ti, first_hs, acc5, sent, n, ov_n;
    logic full_pending;
    logic [WIDTH-1:0] b0, rx, ry;
    logic [TAG_W-1:0] t0;
    logic [TAG_W-1:0] exp_tag[3];
    logic [WIDTH-1:0] exp_res[3];

    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_bits", 64'(bus.out_bits), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    reset_n = 1'b1;
    tick();

    run_one(32'd12, 32'd8, 4'd3);
    run_one(32'd0, 32'd9, 4'd1);
    run_one(32'd9, 32'd0, 4'd2);
    run_one(32'd0, 32'd0, 4'd3);

    // Fill all lanes; the fifth request waits for the first free lane.
    bus.out_ready = 1'b1;
    acc_n = 0; hs_n = 0; ti = 0; first_hs = -1; acc5 = -1; full_pending = 1'b0;
    while ((acc_n < 5 || bus.busy) && ti < 6000) begin
      if (full_pending) begin
        check("full_ready", 64'(bus.in_ready), 64'(0));
        full_pending = 1'b0;
      end
      bus.in_valid = (acc_n < 5);
      bus.in_x = 32'd1000; bus.in_y = 32'd1; bus.in_tag = 4'(acc_n);
      if (bus.out_valid && bus.out_ready) begin
        hs_n++;
        if (first_hs < 0) first_hs = ti;
        check("fill_bits", 64'(bus.out_bits), 64'(1));
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_n++;
        if (acc_n == 4) full_pending = 1'b1;
        if (acc_n == 5) acc5 = ti;
      end
      tick();
      ti++;
    end
    bus.in_valid = 1'b0;
    check("fill_accepts", 64'(acc_n), 64'(5));
    check("fill_results", 64'(hs_n), 64'(5));
    check("fill_5th_accept", 64'(acc5), 64'(first_hs + 1));

    // Short job overtakes long job.
    send(32'd1000, 32'd1, 4'd0);
    send(32'd6, 32'd3, 4'd1);
    wait_valid();
    check("ooo_first_tag", 64'(bus.out_tag), 64'(1));
    check("ooo_first_bits", 64'(bus.out_bits), 64'(3));
    tick();
    wait_valid();
    check("ooo_second_tag", 64'(bus.out_tag), 64'(0));
    check("ooo_second_bits", 64'(bus.out_bits), 64'(1));
    tick();

    // Backpressure with three finished lanes from a fresh pointer.
    do_reset();
    bus.out_ready = 1'b0;
    send(32'd12, 32'd8, 4'd5);
    send(32'd9, 32'd6, 4'd6);
    send(32'd7, 32'd7, 4'd7);
    repeat (10) tick();
    exp_tag[0] = 4'd5; exp_tag[1] = 4'd6; exp_tag[2] = 4'd7;
    exp_res[0] = 32'd4; exp_res[1] = 32'd3; exp_res[2] = 32'd7;
    b0 = bus.out_bits; t0 = bus.out_tag;
    check("bp_valid", 64'(bus.out_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_bits_stable", 64'(bus.out_bits), 64'(b0));
      check("bp_tag_stable", 64'(bus.out_tag), 64'(t0));
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", 64'(bus.out_valid), 64'(1));
      check("drain_tag", 64'(bus.out_tag), 64'(exp_tag[i]));
      check("drain_bits", 64'(bus.out_bits), 64'(exp_res[i]));
      tick();
    end
    check("drain_empty", 64'(bus.out_valid), 64'(0));

    // Reset while two lanes compute.
    send(32'd1000, 32'd1, 4'd8);
    send(32'd999, 32'd1, 4'd9);
    repeat (5) tick();
    reset_n = 1'b0;
    #2;
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_ready", 64'(bus.in_ready), 64'(1));
    tick();
    tick();
    reset_n = 1'b1;
    ov_n = 0;
    for (int i = 0; i < 1010; i++) begin
      if (bus.out_valid) ov_n++;
      tick();
    end
    check("no_stale", 64'(ov_n), 64'(0));
    run_one(32'd12, 32'd8, 4'd2);

    // Random traffic with random backpressure.
    sent = 0; n = 0;
    rx = 32'($urandom_range(0, 60)); ry = 32'($urandom_range(1, 60));
    while (sent < 200 && n < 40000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_x = rx; bus.in_y = ry; bus.in_tag = 4'(sent);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        rx = ($urandom_range(0, 7) == 0) ? '0 : 32'($urandom_range(1, 60));
        ry = 32'($urandom_range(0, 60));
      end
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("rand_sent", 64'(sent), 64'(200));
    n = 0;
    while (bus.busy && n < 2000) begin tick(); n++; end
    tick();
    check("rand_drained", 64'(bus.busy), 64'(0));
    check("sb_empty", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
